// File: rtl/overflow_range_buffer_pkg.sv
// Shared types and constants for the heap-overflow range buffer and its producer.
// The 32-bit range struct and default depth are common with the overflow tracker.
package overflow_range_buffer_pkg;

    localparam int BOF_RANGE_DEPTH = 8;
    localparam int BOF_ADDR_W      = 32;

    typedef struct packed {
        logic [BOF_ADDR_W-1:0] first;
        logic [BOF_ADDR_W-1:0] last;
        logic                  valid;
    } bof_range_t;

    // Outcome of a write strobe in the current cycle.
    typedef enum logic [1:0] {
        WR_IDLE,
        WR_DROP,
        WR_ACCEPT
    } wr_action_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/overflow_range_buffer_if.sv
// Signal bundle between the overflow tracker / load-check path and the range buffer.
// Write strobe has no handshake: every cycle en_write_i is high is one write attempt.
interface overflow_range_buffer_if #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 32
);
    localparam int IDX_W = $clog2(DEPTH);

    logic              clear_i;
    logic              en_write_i;
    logic [ADDR_W-1:0] addr_first_i;
    logic [ADDR_W-1:0] addr_last_i;
    logic [ADDR_W-1:0] find_addr_i;
    logic              addr_in_range_o;
    logic [IDX_W-1:0]  hit_idx_o;
    logic [IDX_W-1:0]  rd_idx_i;
    logic [ADDR_W-1:0] rd_first_o;
    logic [ADDR_W-1:0] rd_last_o;
    logic              rd_valid_o;
    logic [IDX_W:0]    count_o;
    logic              full_o;
    logic              wrapped_o;
    logic [7:0]        drop_cnt_o;

    modport master (
        output clear_i, en_write_i, addr_first_i, addr_last_i, find_addr_i, rd_idx_i,
        input  addr_in_range_o, hit_idx_o, rd_first_o, rd_last_o, rd_valid_o,
               count_o, full_o, wrapped_o, drop_cnt_o
    );

    modport slave (
        input  clear_i, en_write_i, addr_first_i, addr_last_i, find_addr_i, rd_idx_i,
        output addr_in_range_o, hit_idx_o, rd_first_o, rd_last_o, rd_valid_o,
               count_o, full_o, wrapped_o, drop_cnt_o
    );

endinterface

// File: rtl/overflow_range_buffer_match.sv
// Single-entry range comparator: unsigned, inclusive at both ends, gated by valid.
module bof_range_match #(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] i_first,
    input  logic [ADDR_W-1:0] i_last,
    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_match
);

    assign o_match = i_valid && (i_addr >= i_first) && (i_addr <= i_last);

endmodule

// File: rtl/overflow_range_buffer.sv
// Circular store of overflow address ranges with a zero-latency "address in any range" lookup.
// Oldest-first eviction once full; rejected writes are counted in a saturating drop counter.
module overflow_range_buffer
    import overflow_range_buffer_pkg::*;
#(
    parameter int DEPTH  = BOF_RANGE_DEPTH,
    parameter int ADDR_W = BOF_ADDR_W
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    overflow_range_buffer_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] first;
        logic [ADDR_W-1:0] last;
        logic              valid;
    } entry_t;

    entry_t           r_entry [DEPTH];
    logic [IDX_W-1:0] r_wptr;
    logic [IDX_W:0]   r_count;
    logic             r_wrapped;
    logic [7:0]       r_drop_cnt;

    wr_action_e       w_action;
    logic [IDX_W-1:0] w_prev_idx;
    entry_t           w_prev;
    logic [DEPTH-1:0] w_match;
    logic [IDX_W-1:0] w_hit_idx;
    entry_t           w_rd;

    // The most recent write sits just behind the write pointer; pointer math wraps mod DEPTH.
    assign w_prev_idx = r_wptr - IDX_W'(1);
    assign w_prev     = r_entry[w_prev_idx];

    always_comb begin
        w_action = WR_IDLE;
        if (bus.en_write_i) begin
            if (bus.addr_first_i > bus.addr_last_i) begin
                w_action = WR_DROP;
            end else if (w_prev.valid &&
                         (w_prev.first == bus.addr_first_i) &&
                         (w_prev.last  == bus.addr_last_i)) begin
                w_action = WR_DROP;
            end else begin
                w_action = WR_ACCEPT;
            end
        end
    end

    // Clear has priority over a same-cycle write; the lost write is not a drop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entry[i] <= '0;
            end
            r_wptr     <= '0;
            r_count    <= '0;
            r_wrapped  <= 1'b0;
            r_drop_cnt <= '0;
        end else if (bus.clear_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entry[i] <= '0;
            end
            r_wptr     <= '0;
            r_count    <= '0;
            r_wrapped  <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            case (w_action)
                WR_DROP: begin
                    r_drop_cnt <= sat_inc8(r_drop_cnt);
                end
                WR_ACCEPT: begin
                    r_entry[r_wptr].first <= bus.addr_first_i;
                    r_entry[r_wptr].last  <= bus.addr_last_i;
                    r_entry[r_wptr].valid <= 1'b1;
                    r_wptr                <= r_wptr + IDX_W'(1);
                    if (r_entry[r_wptr].valid) begin
                        r_wrapped <= 1'b1;
                    end else begin
                        r_count <= r_count + (IDX_W+1)'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_match
        bof_range_match #(
            .ADDR_W (ADDR_W)
        ) u_match (
            .i_first (r_entry[g].first),
            .i_last  (r_entry[g].last),
            .i_valid (r_entry[g].valid),
            .i_addr  (bus.find_addr_i),
            .o_match (w_match[g])
        );
    end

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        w_hit_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                w_hit_idx = IDX_W'(i);
            end
        end
    end

    assign w_rd = r_entry[bus.rd_idx_i];

    assign bus.addr_in_range_o = |w_match;
    assign bus.hit_idx_o       = w_hit_idx;
    assign bus.rd_valid_o      = w_rd.valid;
    assign bus.rd_first_o      = w_rd.valid ? w_rd.first : '0;
    assign bus.rd_last_o       = w_rd.valid ? w_rd.last  : '0;
    assign bus.count_o         = r_count;
    assign bus.full_o          = (r_count == FULL_CNT);
    assign bus.wrapped_o       = r_wrapped;
    assign bus.drop_cnt_o      = r_drop_cnt;

endmodule

// File: tb/tb_overflow_range_buffer.sv
// Directed bench for overflow_range_buffer at DEPTH=4: lookups go through an expected queue,
// status outputs are compared against constants derived from the stimulus.
module tb_overflow_range_buffer;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;
    localparam int IDX_W  = 2;
    localparam int W      = IDX_W + 1;

    logic clk;
    logic rst_n;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_q[$];

    overflow_range_buffer_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();

    overflow_range_buffer #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // scoreboard: push expected {hit, idx}, let the lookup settle, pop and compare
    task automatic lookup(input string tag, input logic [31:0] a, input logic h,
                          input logic [IDX_W-1:0] idx);
        logic [W-1:0] e;
        bus.find_addr_i = a;
        exp_q.push_back({h, idx});
        #1;
        e = exp_q.pop_front();
        chk(tag, 32'({bus.addr_in_range_o, bus.hit_idx_o}), 32'(e));
    endtask

    task automatic write_range(input logic [31:0] f, input logic [31:0] l);
        @(negedge clk);
        bus.en_write_i   = 1'b1;
        bus.addr_first_i = f;
        bus.addr_last_i  = l;
        @(negedge clk);
        bus.en_write_i   = 1'b0;
        #1;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        bus.clear_i = 1'b1;
        @(negedge clk);
        bus.clear_i = 1'b0;
        #1;
    endtask

    task automatic check_status(input string tag, input int cnt, input logic full,
                                input logic wrapped, input int drops);
        chk({tag, "_count"},   32'(bus.count_o),    32'(cnt));
        chk({tag, "_full"},    32'(bus.full_o),     32'(full));
        chk({tag, "_wrapped"}, 32'(bus.wrapped_o),  32'(wrapped));
        chk({tag, "_drop"},    32'(bus.drop_cnt_o), 32'(drops));
    endtask

    logic [31:0] r_first [5];
    logic [31:0] r_last  [5];

    initial begin
        rst_n            = 1'b0;
        bus.clear_i      = 1'b0;
        bus.en_write_i   = 1'b0;
        bus.addr_first_i = '0;
        bus.addr_last_i  = '0;
        bus.find_addr_i  = '0;
        bus.rd_idx_i     = '0;
        for (int i = 0; i < 5; i++) begin
            r_first[i] = 32'h0001_0000 + 32'(i) * 32'h100;
            r_last[i]  = r_first[i] + 32'hFF;
        end

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;

        // reset state
        lookup("reset_lookup", 32'h1000, 1'b0, 2'd0);
        check_status("reset", 0, 1'b0, 1'b0, 0);
        for (int i = 0; i < DEPTH; i++) begin
            bus.rd_idx_i = IDX_W'(i);
            #1;
            chk("reset_rd_valid", 32'(bus.rd_valid_o), 32'd0);
        end

        // single range, lookup in the write cycle sees old contents
        @(negedge clk);
        bus.en_write_i   = 1'b1;
        bus.addr_first_i = 32'h1000;
        bus.addr_last_i  = 32'h1040;
        lookup("write_cycle_miss", 32'h1000, 1'b0, 2'd0);
        @(negedge clk);
        bus.en_write_i = 1'b0;
        lookup("single_first", 32'h1000, 1'b1, 2'd0);
        lookup("single_last",  32'h1040, 1'b1, 2'd0);
        lookup("single_above", 32'h1041, 1'b0, 2'd0);
        lookup("single_below", 32'h0FFF, 1'b0, 2'd0);
        chk("single_count", 32'(bus.count_o), 32'd1);

        // fill then evict the oldest
        pulse_clear();
        for (int i = 0; i < 4; i++) write_range(r_first[i], r_last[i]);
        check_status("full", 4, 1'b1, 1'b0, 0);
        lookup("full_r3", r_last[3], 1'b1, 2'd3);
        write_range(r_first[4], r_last[4]);
        check_status("wrap", 4, 1'b1, 1'b1, 0);
        lookup("wrap_r0_gone", r_first[0], 1'b0, 2'd0);
        lookup("wrap_r4_hit",  r_first[4], 1'b1, 2'd0);
        lookup("wrap_r1_hit",  r_last[1],  1'b1, 2'd1);
        bus.rd_idx_i = 2'd0;
        #1;
        chk("wrap_rd_first", bus.rd_first_o, r_first[4]);
        chk("wrap_rd_last",  bus.rd_last_o,  r_last[4]);
        chk("wrap_rd_valid", 32'(bus.rd_valid_o), 32'd1);

        // rejected writes
        write_range(32'h2000, 32'h1FFF);
        check_status("inverted", 4, 1'b1, 1'b1, 1);
        lookup("inverted_nohit", 32'h2000, 1'b0, 2'd0);
        write_range(r_first[4], r_last[4]);
        check_status("duplicate", 4, 1'b1, 1'b1, 2);
        @(negedge clk);
        bus.en_write_i   = 1'b1;
        bus.addr_first_i = 32'h2000;
        bus.addr_last_i  = 32'h1FFF;
        repeat (300) @(negedge clk);
        bus.en_write_i = 1'b0;
        #1;
        check_status("saturate", 4, 1'b1, 1'b1, 255);

        // overlapping ranges, lowest index wins
        pulse_clear();
        check_status("clear", 0, 1'b0, 1'b0, 0);
        write_range(32'h100, 32'h1FF);
        write_range(32'h180, 32'h2FF);
        lookup("overlap_190", 32'h190, 1'b1, 2'd0);
        lookup("overlap_250", 32'h250, 1'b1, 2'd1);
        lookup("overlap_180", 32'h180, 1'b1, 2'd0);
        lookup("overlap_2ff", 32'h2FF, 1'b1, 2'd1);
        lookup("overlap_300", 32'h300, 1'b0, 2'd0);
        chk("overlap_count", 32'(bus.count_o), 32'd2);

        // clear beats a same-cycle write and is not a drop
        write_range(32'h10, 32'h0F);
        chk("pre_clear_drop", 32'(bus.drop_cnt_o), 32'd1);
        @(negedge clk);
        bus.clear_i      = 1'b1;
        bus.en_write_i   = 1'b1;
        bus.addr_first_i = 32'h5000;
        bus.addr_last_i  = 32'h50FF;
        @(negedge clk);
        bus.clear_i    = 1'b0;
        bus.en_write_i = 1'b0;
        #1;
        check_status("clear_write", 0, 1'b0, 1'b0, 0);
        lookup("clear_write_miss", 32'h5000, 1'b0, 2'd0);
        lookup("clear_old_miss",   32'h190,  1'b0, 2'd0);

        // asynchronous reset in the middle of a write burst
        @(negedge clk);
        bus.en_write_i   = 1'b1;
        bus.addr_first_i = 32'h7000;
        bus.addr_last_i  = 32'h70FF;
        @(negedge clk);
        bus.addr_first_i = 32'h7100;
        bus.addr_last_i  = 32'h71FF;
        @(negedge clk);
        bus.addr_first_i = 32'h7200;
        bus.addr_last_i  = 32'h72FF;
        bus.rd_idx_i     = 2'd0;
        lookup("burst_hit", 32'h7100, 1'b1, 2'd1);
        chk("burst_count", 32'(bus.count_o), 32'd2);
        #1;
        rst_n = 1'b0;
        #1;
        check_status("async_rst", 0, 1'b0, 1'b0, 0);
        lookup("async_rst_miss", 32'h7000, 1'b0, 2'd0);
        chk("async_rst_rd_valid", 32'(bus.rd_valid_o), 32'd0);
        bus.en_write_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // time bound so the run always ends with a summary line
    initial begin
        #200000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
